// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU frame loader: table geometry, the loader
// state encoding and a small helper for the active-area test.
package gpu_pkg;

    localparam int          RECT_COUNT  = 64;
    localparam int          RECT_WORDS  = 6;
    localparam int          TABLE_WORDS = RECT_COUNT * RECT_WORDS;
    localparam logic [15:0] TABLE_BASE  = 16'hFE80;

    localparam int          H_ACTIVE_DEFAULT    = 640;
    localparam int          V_ACTIVE_DEFAULT    = 480;
    localparam int          RAM_LATENCY_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        DONE
    } load_state_e;

    // True when the beam position lies outside the visible picture.
    function automatic logic outside_active(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic [15:0] h_lim,
                                            input logic [15:0] v_lim);
        return (x >= h_lim) || (y >= v_lim);
    endfunction

endpackage

// File: rtl/gpu_frame_loader_valid_delay.sv
// Fixed-depth shift register that delays a single valid bit so the gpu write
// strobe lines up with the data returned by the video RAM.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Next contents of the delay line: new bit enters at stage 0.
    always_comb begin
        shift_d    = '0;
        shift_d[0] = in;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Delay line register; reset empties it so no stale strobe survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q[DEPTH-1];

endmodule

// File: rtl/gpu_frame_loader.sv
// Once per frame, at the start of vertical blanking, copies the rectangle
// table from video RAM into the gpu, then releases a waiting CPU.
module gpu_frame_loader
    import gpu_pkg::*;
#(
    parameter int          H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int          V_ACTIVE    = V_ACTIVE_DEFAULT,
    parameter logic [15:0] BASE_ADDR   = TABLE_BASE,
    parameter int          WORDS       = TABLE_WORDS,
    parameter int          RAM_LATENCY = RAM_LATENCY_DEFAULT
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [15:0] x_coord,
    input  logic [15:0] y_coord,
    input  logic        enable,
    input  logic        cpu_wait,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        gpu_we,
    output logic [15:0] gpu_din,
    output logic        gpu_idle,
    output logic        cpu_resume,
    output logic        busy,
    output logic        overrun
);

    localparam logic [15:0] H_LIM      = 16'(H_ACTIVE);
    localparam logic [15:0] V_LIM      = 16'(V_ACTIVE);
    localparam logic [15:0] LAST_WORD  = 16'(WORDS - 1);
    localparam logic [15:0] LAST_DRAIN = 16'(RAM_LATENCY - 1);

    load_state_e state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] drain_q, drain_d;
    logic        skip_resume_q, skip_resume_d;
    logic        done_resume;
    logic        addr_valid;
    logic        trigger;
    logic        frame_start;
    logic        idle_q, idle_d;
    logic        overrun_q, overrun_d;
    logic [15:0] din_q;

    assign trigger     = (x_coord == 16'd0) && (y_coord == V_LIM);
    assign frame_start = (x_coord == 16'd0) && (y_coord == 16'd0);

    // Next-state logic: walk the table one word per cycle, wait for the RAM
    // pipeline to empty, then spend one cycle releasing the CPU.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        addr_d        = addr_q;
        drain_d       = drain_q;
        skip_resume_d = 1'b0;
        done_resume   = 1'b0;
        addr_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (enable) begin
                        state_d = COPY;
                        word_d  = '0;
                        addr_d  = BASE_ADDR;
                    end else begin
                        skip_resume_d = cpu_wait;
                    end
                end
            end
            COPY: begin
                addr_valid = 1'b1;
                if (word_q == LAST_WORD) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    word_d = word_q + 16'd1;
                    addr_d = addr_q + 16'd1;
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 16'd1;
                end
            end
            DONE: begin
                done_resume = cpu_wait;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader state, counters and the address register.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            word_q        <= '0;
            addr_q        <= BASE_ADDR;
            drain_q       <= '0;
            skip_resume_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
            drain_q       <= drain_d;
            skip_resume_q <= skip_resume_d;
        end
    end

    // The write strobe trails the address by the RAM read latency.
    valid_delay #(
        .DEPTH (RAM_LATENCY)
    ) u_we_delay (
        .clk   (pixel_clk),
        .rst_n (reset),
        .in    (addr_valid),
        .out   (gpu_we)
    );

    assign busy      = (state_q == COPY) || (state_q == DRAIN);
    assign idle_d    = outside_active(x_coord, y_coord, H_LIM, V_LIM);
    assign overrun_d = overrun_q || (busy && frame_start);

    // Status registers: blanking indicator, sticky overrun, and the data
    // hold register that keeps the last streamed word on gpu_din.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            idle_q    <= 1'b1;
            overrun_q <= 1'b0;
            din_q     <= '0;
        end else begin
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
            din_q     <= gpu_din;
        end
    end

    assign gpu_din    = gpu_we ? mem_rdata : din_q;
    assign mem_addr   = addr_q;
    assign gpu_idle   = idle_q;
    assign overrun    = overrun_q;
    assign cpu_resume = done_resume || skip_resume_q;

endmodule

// File: tb/tb_gpu_frame_loader.sv
// Directed bench for gpu_frame_loader: a table of single-cycle vectors for
// the idle/trigger logic plus hand-written multi-cycle load sequences.
`timescale 1ns/1ps
module tb_gpu_frame_loader;

    localparam int WORDS = 384;

    logic        pixelClk;
    logic        resetN;
    logic [15:0] xCoord;
    logic [15:0] yCoord;
    logic        enable;
    logic        cpuWait;
    logic [15:0] memAddr;
    logic [15:0] memRdata;
    logic        gpuWe;
    logic [15:0] gpuDin;
    logic        gpuIdle;
    logic        cpuResume;
    logic        busy;
    logic        overrun;
    logic [15:0] ramXor;

    int checkCount;
    int passCount;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        en;
        logic        cpuWaitIn;
        logic        expIdle;
        logic        expResume;
    } vecT;

    vecT vecs[11];

    gpu_frame_loader dut (
        .pixel_clk  (pixelClk),
        .reset      (resetN),
        .x_coord    (xCoord),
        .y_coord    (yCoord),
        .enable     (enable),
        .cpu_wait   (cpuWait),
        .mem_addr   (memAddr),
        .mem_rdata  (memRdata),
        .gpu_we     (gpuWe),
        .gpu_din    (gpuDin),
        .gpu_idle   (gpuIdle),
        .cpu_resume (cpuResume),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Free-running pixel clock.
    initial pixelClk = 1'b0;
    always #5 pixelClk = ~pixelClk;

    // Video RAM with one cycle of read latency; table word i holds i ^ ramXor.
    always @(posedge pixelClk) begin
        memRdata <= (memAddr - 16'hFE80) ^ ramXor;
    end

    // Hard stop in case something wedges the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, and report it when it goes wrong.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drive one table vector for a single cycle and land just after the edge.
    task automatic applyStimulus(input vecT v);
        xCoord  = v.x;
        yCoord  = v.y;
        enable  = v.en;
        cpuWait = v.cpuWaitIn;
        @(posedge pixelClk);
        #1;
    endtask

    // Full load starting with a trigger in cycle 0; checks timing, data and
    // resume behaviour. Optionally injects a frame start and a second
    // trigger mid-load.
    task automatic runLoad(input string tag, input logic [15:0] xorVal,
                           input logic waitVal, input int yZeroCycle,
                           input int retrigCycle);
        int   firstWe, lastWe, weCnt, dinErr, addrErr;
        int   resumeCnt, resumeAt, busyFall;
        logic ovBefore;
        firstWe   = -1;
        lastWe    = -1;
        weCnt     = 0;
        dinErr    = 0;
        addrErr   = 0;
        resumeCnt = 0;
        resumeAt  = -1;
        busyFall  = -1;
        ovBefore  = 1'b1;
        ramXor    = xorVal;
        cpuWait   = waitVal;
        enable    = 1'b1;
        for (int c = 0; c <= 396; c++) begin
            xCoord = 16'(c);
            yCoord = 16'd480;
            if (c > 0 && c == yZeroCycle) begin
                xCoord = 16'd0;
                yCoord = 16'd0;
            end
            if (c > 0 && c == retrigCycle) begin
                xCoord = 16'd0;
            end
            @(negedge pixelClk);
            if (c >= 1 && c <= WORDS && memAddr != 16'(32'hFE80 + c - 1)) addrErr++;
            if (gpuWe) begin
                if (firstWe < 0) firstWe = c;
                lastWe = c;
                weCnt++;
                if (gpuDin != (16'(c - 2) ^ xorVal)) dinErr++;
            end
            if (c >= 1 && !busy && busyFall < 0) busyFall = c;
            if (cpuResume) begin
                resumeCnt++;
                resumeAt = c;
            end
            if (c == yZeroCycle) ovBefore = overrun;
            @(posedge pixelClk);
            #1;
        end
        checkOutput({tag, " first_we_cycle"}, firstWe, 2);
        checkOutput({tag, " last_we_cycle"}, lastWe, 385);
        checkOutput({tag, " we_count"}, weCnt, WORDS);
        checkOutput({tag, " din_errors"}, dinErr, 0);
        checkOutput({tag, " addr_errors"}, addrErr, 0);
        checkOutput({tag, " busy_fall_cycle"}, busyFall, 386);
        checkOutput({tag, " addr_hold"}, memAddr, 16'hFFFF);
        checkOutput({tag, " resume_count"}, resumeCnt, waitVal ? 1 : 0);
        if (waitVal) checkOutput({tag, " resume_cycle"}, resumeAt, 386);
        if (yZeroCycle > 0) begin
            checkOutput({tag, " overrun_before"}, ovBefore, 0);
            checkOutput({tag, " overrun_after"}, overrun, 1);
        end
    endtask

    // Main sequence.
    initial begin
        int lateResumes;
        checkCount = 0;
        passCount  = 0;
        ramXor     = 16'h0000;
        resetN     = 1'b0;
        xCoord     = 16'd0;
        yCoord     = 16'd0;
        enable     = 1'b0;
        cpuWait    = 1'b0;

        // Reset values, with coordinates inside the active area.
        repeat (2) @(posedge pixelClk);
        #1;
        checkOutput("reset idle", gpuIdle, 1);
        checkOutput("reset addr", memAddr, 16'hFE80);
        checkOutput("reset we", gpuWe, 0);
        checkOutput("reset din", gpuDin, 0);
        checkOutput("reset resume", cpuResume, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset overrun", overrun, 0);
        @(negedge pixelClk);
        resetN = 1'b1;
        @(posedge pixelClk);
        #1;

        // Single-cycle vectors: idle boundaries and skipped loads.
        vecs[0]  = '{16'd639,   16'd0,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'd640,   16'd0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'd0,     16'd479, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'd0,     16'd480, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{16'd5,     16'd480, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16'd0,     16'd480, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'd100,   16'd100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'd65535, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'd0,     16'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'd639,   16'd479, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'd1,     16'd480, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d idle", i), gpuIdle, vecs[i].expIdle);
            checkOutput($sformatf("vec%0d resume", i), cpuResume, vecs[i].expResume);
            checkOutput($sformatf("vec%0d busy", i), busy, 0);
            checkOutput($sformatf("vec%0d we", i), gpuWe, 0);
            checkOutput($sformatf("vec%0d addr", i), memAddr, 16'hFE80);
            checkOutput($sformatf("vec%0d overrun", i), overrun, 0);
        end

        // gpu_idle must still show the old coordinates until the next edge.
        xCoord  = 16'd639;
        yCoord  = 16'd0;
        cpuWait = 1'b0;
        @(posedge pixelClk);
        #1;
        xCoord = 16'd640;
        #2;
        checkOutput("idle lag x before edge", gpuIdle, 0);
        @(posedge pixelClk);
        #1;
        checkOutput("idle lag x after edge", gpuIdle, 1);
        xCoord = 16'd7;
        yCoord = 16'd479;
        @(posedge pixelClk);
        #1;
        yCoord = 16'd480;
        #2;
        checkOutput("idle lag y before edge", gpuIdle, 0);
        @(posedge pixelClk);
        #1;
        checkOutput("idle lag y after edge", gpuIdle, 1);

        // Full loads: CPU waiting, then CPU not waiting.
        runLoad("load_wait", 16'h0000, 1'b1, 0, 0);
        runLoad("load_nowait", 16'h5A5A, 1'b0, 0, 0);

        // CPU starts waiting well after DONE: no release until next frame.
        cpuWait     = 1'b1;
        lateResumes = 0;
        for (int c = 0; c < 20; c++) begin
            xCoord = 16'(c + 500);
            yCoord = 16'd480;
            @(negedge pixelClk);
            if (cpuResume) lateResumes++;
            @(posedge pixelClk);
            #1;
        end
        checkOutput("late wait no resume", lateResumes, 0);
        runLoad("load_late_wait", 16'h00FF, 1'b1, 0, 0);

        // Reset while word 100 is being written aborts the load silently.
        ramXor  = 16'h0000;
        cpuWait = 1'b1;
        enable  = 1'b1;
        xCoord  = 16'd0;
        yCoord  = 16'd480;
        for (int c = 1; c <= 102; c++) begin
            @(posedge pixelClk);
            #1;
            xCoord = 16'(c);
        end
        #1;
        checkOutput("abort we before reset", gpuWe, 1);
        checkOutput("abort din word100", gpuDin, 16'd100);
        resetN = 1'b0;
        #1;
        checkOutput("abort we", gpuWe, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort resume", cpuResume, 0);
        @(negedge pixelClk);
        resetN = 1'b1;
        @(posedge pixelClk);
        #1;
        lateResumes = 0;
        for (int c = 0; c < 10; c++) begin
            xCoord = 16'(c + 200);
            @(negedge pixelClk);
            if (cpuResume) lateResumes++;
            @(posedge pixelClk);
            #1;
        end
        checkOutput("abort no resume", lateResumes, 0);
        runLoad("load_after_abort", 16'h1234, 1'b1, 0, 0);

        // Frame restarts mid-load and a stray trigger arrives: the load
        // still completes normally and overrun sticks.
        runLoad("load_overrun", 16'hA5A5, 1'b1, 50, 100);
        for (int c = 0; c < 20; c++) begin
            xCoord = 16'(c + 700);
            @(posedge pixelClk);
            #1;
        end
        checkOutput("overrun sticky", overrun, 1);
        resetN = 1'b0;
        #1;
        checkOutput("overrun cleared by reset", overrun, 0);
        checkOutput("idle during reset", gpuIdle, 1);
        @(negedge pixelClk);
        resetN = 1'b1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
